// File: rtl/alu_cond_flag_unit.sv
// alu_cond_flag_unit
//   Holds the architectural NZCV flag register that follows ALU_32_Bit.
//   Evaluates the ARM 4-bit condition field against the registered flags.
//   Gates the decoder's register-write, memory-write and PC-source strobes
//   with the condition result.
//   A one-entry shadow register lets the flags be saved on exception entry
//   and restored on return.
//
// Parameters
//   RESET_FLAGS    reset value of the flag and shadow registers, {N,Z,C,V}
//   SHADOW_EN      1 = shadow save/restore present, 0 = save/restore ignored
//
// Ports
//   i_clk          system clock, rising edge
//   i_RESET        asynchronous active-high reset
//   i_ALUFlags     ALU flags {N,Z,C,V}
//   i_Cond         instruction condition field
//   i_FlagW        [1] update N,Z   [0] update C,V
//   i_RegW/i_MemW/i_PCS   decoder strobes before condition gating
//   i_FlagSave     copy flags into the shadow
//   i_FlagRestore  load the shadow into the flags
//   o_Flags        registered flags {N,Z,C,V}
//   o_CondEx       condition passed this cycle
//   o_RegWrite/o_MemWrite/o_PCSrc   strobes gated by o_CondEx
module alu_cond_flag_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         SHADOW_EN   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_RESET,
    input  logic [3:0] i_ALUFlags,
    input  logic [3:0] i_Cond,
    input  logic [1:0] i_FlagW,
    input  logic       i_RegW,
    input  logic       i_MemW,
    input  logic       i_PCS,
    input  logic       i_FlagSave,
    input  logic       i_FlagRestore,
    output logic [3:0] o_Flags,
    output logic       o_CondEx,
    output logic       o_RegWrite,
    output logic       o_MemWrite,
    output logic       o_PCSrc
);

    logic [3:0] flags;
    logic [3:0] shadow;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_pass;
    logic       do_save;
    logic       do_restore;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    assign do_save    = SHADOW_EN && i_FlagSave;
    assign do_restore = SHADOW_EN && i_FlagRestore;

    // Evaluated against the registered flags, never the incoming ALU flags,
    // so an instruction's own flag result cannot affect its condition.
    always_comb begin
        cond_pass = 1'b0;
        unique case (i_Cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // Reset masks the condition so no strobe can fire while in reset.
    assign o_CondEx   = cond_pass && !i_RESET;
    assign o_RegWrite = i_RegW && o_CondEx;
    assign o_MemWrite = i_MemW && o_CondEx;
    assign o_PCSrc    = i_PCS  && o_CondEx;
    assign o_Flags    = flags;

    // Restore wins over any flag write in the same cycle.
    always_ff @(posedge i_clk or posedge i_RESET) begin
        if (i_RESET) begin
            flags <= RESET_FLAGS;
        end else if (do_restore) begin
            flags <= shadow;
        end else begin
            if (i_FlagW[1] && o_CondEx) flags[3:2] <= i_ALUFlags[3:2];
            if (i_FlagW[0] && o_CondEx) flags[1:0] <= i_ALUFlags[1:0];
        end
    end

    // Shadow captures the pre-update flags; save+restore together swaps.
    always_ff @(posedge i_clk or posedge i_RESET) begin
        if (i_RESET) begin
            shadow <= RESET_FLAGS;
        end else if (do_save) begin
            shadow <= flags;
        end
    end

endmodule
